fx3_spi_slave: RTL
==================

Name: fx3_spi_slave

Overview:
- SPI responder for the FX3 SPI master pins (fx3_ce / fx3_sclk / fx3_mosi / fx3_miso), which currently have no logic behind them.
- Lets FX3 firmware write the settings bus and read the readback mux over SPI, independently of GPIF.
- Sits in the bus_clk domain between the pins and b200_core's settings/readback ports. The top level owns the miso tristate.

Parameters:
- DWIDTH, 32, data payload width in bits
- AWIDTH, 7, register address width; command byte is {rd_nwr, addr[AWIDTH-1:0]}, so AWIDTH+1 = 8
- SYNC_STAGES, 2, synchroniser flops on sclk, cs_n and mosi

Ports:
- clk  in  1  bus_clk, 100 MHz
- reset_n  in  1  synchronous, active-low
- spi_sclk  in  1  async from FX3; CPOL=0
- spi_cs_n  in  1  async from FX3 (fx3_ce), active-low
- spi_mosi  in  1  async from FX3, MSB first
- spi_miso  out  1  serial read data
- spi_miso_oe  out  1  high = top drives fx3_miso, low = top drives Z
- set_stb  out  1  one-cycle settings write strobe
- set_addr  out  AWIDTH  settings address
- set_data  out  DWIDTH  settings data
- rb_stb  out  1  one-cycle readback request
- rb_addr  out  AWIDTH  readback address
- rb_data  in  DWIDTH  readback value, valid 2 clk after rb_stb
- frame_err  out  1  one-cycle pulse on a truncated frame

Behaviour:
- Synchronisation and edge detection:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops, then one history flop for edge detection.
  - Detect latency is 3 clk from the pin.
  - mosi is sampled on detected sclk rise.
- SPI mode 0. Frame = 8-bit command + DWIDTH data bits, MSB first, 40 bits total.
- Timing requirement on FX3: sclk high ≥ 6 clk and low ≥ 6 clk (≤ 8 MHz at 100 MHz); cs_n high ≥ 4 clk between frames.
- Reset values: spi_miso=0, spi_miso_oe=0, set_stb=0, set_addr=0, set_data=0, rb_stb=0, rb_addr=0, frame_err=0. FSM enters WAIT_IDLE.
- FSM states:
  - WAIT_IDLE: entered after reset. Leave to IDLE only once synced cs_n=1 is seen, so a frame already in progress at reset release is ignored entirely.
  - IDLE: bit_cnt=0, spi_miso_oe=0. Synced cs_n falling goes to CMD; spi_miso_oe=1 and spi_miso=0 from the next cycle.
  - CMD: shift 8 bits.
    - 8th rise with cmd[7]=1 (read): rb_addr=cmd[6:0]; rb_stb pulses the following cycle; rb_data is captured into tx_shift 2 clk after rb_stb. Go to DATA_RD.
    - 8th rise with cmd[7]=0 (write): go to DATA_WR.
  - DATA_RD: on each detected sclk fall, spi_miso <= tx_shift[MSB] and tx_shift shifts left. The first fall after the 8th rise presents rb_data[31]. After 32 more rises, go to DONE.
  - DATA_WR: shift mosi into rx_shift. On the 40th rise, the next cycle sets set_addr=cmd[6:0], set_data=rx_shift, and pulses set_stb. set_addr/set_data hold until the next write. Go to DONE.
  - DONE: additional sclk edges are ignored; no second strobe; spi_miso=0.
- cs_n rise (synced), from any state except WAIT_IDLE/IDLE: return to IDLE; spi_miso_oe=0 the next cycle.
  - If bit_cnt was in 1..39, frame_err pulses 1 cycle and no set_stb is issued.
  - A truncated read still has its rb_stb if 8 bits completed.
  - bit_cnt=0 or a completed frame gives no error.
- cs_n rise and an sclk rise detected in the same cycle: the cs_n rise wins; that bit is discarded.
- reset_n low mid-frame: all outputs return to reset values next clk; FSM goes to WAIT_IDLE.
- bit_cnt is 6 bits and saturates at 40; it never wraps.

Test Plan:
- Write frame cmd=0x05, data=0xDEADBEEF, sclk 5 MHz → exactly one set_stb; set_addr=0x05, set_data=0xDEADBEEF; frame_err=0.
- Read frame cmd=0x92, bench returns rb_data=0xA5A50F0F 2 clk after rb_stb → rb_addr=0x12, one rb_stb; MISO bits sampled by the master on rises 9..40 = 0xA5A50F0F; spi_miso_oe falls within 4 clk of cs_n rise.
- Write aborted after 20 bits (cs_n rises) → frame_err one pulse, no set_stb; a following full write 0x01/0x00000001 completes normally.
- reset_n pulsed low at bit 12 with cs_n held low for 28 more bits → no set_stb, no frame_err; after a cs_n high ≥ 4 clk, the next write frame strobes correctly.
- 48-bit write frame (8 trailing bits) → a single set_stb carrying the first 32 data bits; no frame_err.
- Two back-to-back frames (write 0x03/0x12345678, then read 0x83) with cs_n high 4 clk between them → both are serviced; set_stb and rb_stb each pulse once.

Source files
------------

// File: rtl/fx3_spi_slave.sv
// fx3_spi_slave: mode-0 SPI responder bridging FX3 firmware to the settings bus and readback mux.
// Frame = {rd_nwr, addr} command followed by DWIDTH data bits, MSB first, sampled in the clk domain.
module fx3_spi_slave #(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              set_stb,
   output logic [AWIDTH-1:0] set_addr,
   output logic [DWIDTH-1:0] set_data,
   output logic              rb_stb,
   output logic [AWIDTH-1:0] rb_addr,
   input  logic [DWIDTH-1:0] rb_data,
   output logic              frame_err
);
   localparam int FRAME = AWIDTH + 1 + DWIDTH;
   localparam logic [5:0] CMD_LAST = 6'(AWIDTH);
   localparam logic [5:0] LAST     = 6'(FRAME - 1);
   localparam logic [5:0] FULL     = 6'(FRAME);

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, DATA_RD, DATA_WR, DONE} state_t;
   state_t state;

   logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
   logic                   sclk_d, cs_d;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, cs_now, mosi_b;
   logic [AWIDTH:0]        cmd, cmd_nx;
   logic [5:0]             bit_cnt;
   logic [DWIDTH-1:0]      rx_shift, tx_shift;
   logic [1:0]             rb_dly;

   always_comb begin
      cs_now    = cs_s[SYNC_STAGES-1];
      mosi_b    = mosi_s[SYNC_STAGES-1];
      sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_d;
      sclk_fall = ~sclk_s[SYNC_STAGES-1] & sclk_d;
      cs_rise   = cs_now & ~cs_d;
      cs_fall   = ~cs_now & cs_d;
      cmd_nx    = {cmd[AWIDTH-1:0], mosi_b};
   end

   // Chains clear to 0 so a cs_n held low across reset release never looks like a fresh frame start.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sclk_s <= '0;
         cs_s   <= '0;
         mosi_s <= '0;
         sclk_d <= 1'b0;
         cs_d   <= 1'b0;
      end else begin
         sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi_sclk};
         cs_s   <= {cs_s[SYNC_STAGES-2:0], spi_cs_n};
         mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
         sclk_d <= sclk_s[SYNC_STAGES-1];
         cs_d   <= cs_now;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= WAIT_IDLE;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         set_stb     <= 1'b0;
         set_addr    <= '0;
         set_data    <= '0;
         rb_stb      <= 1'b0;
         rb_addr     <= '0;
         frame_err   <= 1'b0;
         cmd         <= '0;
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         rb_dly      <= '0;
      end else begin
         set_stb   <= 1'b0;
         rb_stb    <= 1'b0;
         frame_err <= 1'b0;
         rb_dly    <= {rb_dly[0], rb_stb};
         // Readback value is valid two cycles after the strobe, well before the first data fall.
         if (rb_dly[1])
            tx_shift <= rb_data;
         else if (state == DATA_RD && !cs_rise && sclk_fall)
            tx_shift <= tx_shift << 1;
         case (state)
            WAIT_IDLE: if (cs_now) state <= IDLE;
            IDLE: begin
               bit_cnt     <= '0;
               spi_miso    <= 1'b0;
               spi_miso_oe <= cs_fall;
               if (cs_fall) state <= CMD;
            end
            default: begin
               if (cs_rise) begin
                  state       <= IDLE;
                  spi_miso    <= 1'b0;
                  spi_miso_oe <= 1'b0;
                  frame_err   <= bit_cnt != '0 && bit_cnt != FULL;
               end else begin
                  if (sclk_rise && bit_cnt != FULL) bit_cnt <= bit_cnt + 6'd1;
                  if (state == CMD && sclk_rise) begin
                     cmd <= cmd_nx;
                     if (bit_cnt == CMD_LAST) begin
                        state <= cmd_nx[AWIDTH] ? DATA_RD : DATA_WR;
                        if (cmd_nx[AWIDTH]) begin
                           rb_addr <= cmd_nx[AWIDTH-1:0];
                           rb_stb  <= 1'b1;
                        end
                     end
                  end
                  if (state == DATA_WR && sclk_rise) begin
                     rx_shift <= {rx_shift[DWIDTH-2:0], mosi_b};
                     if (bit_cnt == LAST) begin
                        set_addr <= cmd[AWIDTH-1:0];
                        set_data <= {rx_shift[DWIDTH-2:0], mosi_b};
                        set_stb  <= 1'b1;
                        state    <= DONE;
                     end
                  end
                  if (state == DATA_RD) begin
                     if (sclk_fall) spi_miso <= tx_shift[DWIDTH-1];
                     if (sclk_rise && bit_cnt == LAST) state <= DONE;
                  end
                  if (state == DONE) spi_miso <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule
